// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32M divide unit.
package rv_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = '1;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/rv_div_unit_div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Shift in the next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[XLEN] == 1'b0) begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module rv_div_unit
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    div_state_e      state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;

    logic [XLEN-1:0] rem_n, quo_n;
    logic            in_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_n),
        .quo_o     (quo_n)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    // Next-state: operand capture, special cases, iteration and sign fix.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        rd_d     = rd_q;

        in_signed = ~op[0];
        a_neg     = in_signed & rs1_data[XLEN-1];
        b_neg     = in_signed & rs2_data[XLEN-1];
        a_mag     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
        b_mag     = b_neg ? (~rs2_data + 1'b1) : rs2_data;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d   = muldiv_op_e'(op);
                    rd_d   = rd_addr;
                    cnt_d  = '0;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    dvs_d  = b_mag;
                    quo_d  = a_mag;
                    rem_d  = '0;
                    if (rs2_data == '0) begin
                        result_d = op[1] ? rs1_data : DIV_BY_ZERO_Q;
                        state_d  = S_DONE;
                    end else if (in_signed && rs1_data == INT_MIN && rs2_data == '1) begin
                        result_d = op[1] ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        // Final iteration's outputs feed the sign fix directly.
                        if (op_q == OP_REM || op_q == OP_REMU)
                            result_d = negr_q ? (~rem_n + 1'b1) : rem_n;
                        else
                            result_d = negq_q ? (~quo_n + 1'b1) : quo_n;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit against an arithmetic reference model.
module tb_rv_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    rv_div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics expressed with plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'b01: return a / b;
            2'b10: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int lat;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("latency", 32'(lat), is_special(o, a, b) ? 32'd1 : 32'd33);
        check("result", result, ref_div(o, a, b));
        check("rd_out", {27'b0, rd_out}, {27'b0, rd});
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("busy_fall", {31'b0, busy}, 32'd0);
        check("result_hold", result, ref_div(o, a, b));
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        int lat, n, first_lat;
        logic [31:0] prev, a, b;
        logic [1:0]  o;
        logic [31:0] first_res;
        logic [4:0]  first_rd;

        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_op(2'b01, 32'd100, 32'd7, 5'd3);
        run_op(2'b11, 32'd100, 32'd7, 5'd4);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7);
        run_op(2'b01, 32'd5, 32'd0, 5'd8);
        run_op(2'b11, 32'd5, 32'd0, 5'd9);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd0, 5'd12);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd13);

        // Start while busy must be ignored
        @(negedge clk);
        op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; n = 0; first_lat = 0; first_res = '0; first_rd = '0;
        while (lat < 80) begin
            if (lat == 5) begin
                op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr = 5'd9; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) begin
                n++;
                if (n == 1) begin
                    first_lat = lat; first_res = result; first_rd = rd_out;
                end
            end
        end
        check("busy_start_dones", 32'(n), 32'd1);
        check("busy_start_latency", 32'(first_lat), 32'd33);
        check("busy_start_result", first_res, 32'd14);
        check("busy_start_rd", {27'b0, first_rd}, 32'd3);

        // Flush mid-calculation
        prev = result;
        @(negedge clk);
        op = 2'b00; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (lat < 10) begin @(posedge clk); #1; lat++; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        count_dones(40, n);
        check("flush_no_done", 32'(n), 32'd0);
        check("flush_result_kept", result, prev);
        run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd14);

        // Flush and start together in IDLE
        @(negedge clk);
        op = 2'b01; rs1_data = 32'd50; rs2_data = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {31'b0, busy}, 32'd0);
        count_dones(3, n);
        check("flush_start_no_done", 32'(n), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        op = 2'b01; rs1_data = 32'h1234_5678; rs2_data = 32'd3; rd_addr = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (lat < 20) begin @(posedge clk); #1; lat++; end
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'b0, rd_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        count_dones(40, n);
        check("rst_no_done", 32'(n), 32'd0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(o, a, b, 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
